// File: rtl/psum_accumulator_pkg.sv
// psum_accumulator_pkg: shared state encoding, default widths and saturation limits
package psum_accumulator_pkg;
   localparam int PROD_W_DEF = 8;
   localparam int ACC_W_DEF  = 16;
   localparam int CNT_W_DEF  = 8;
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      HOLD  = 2'd2
   } state_t;
   localparam logic [ACC_W_DEF-1:0] SAT_POS_DEF = {1'b0, {(ACC_W_DEF-1){1'b1}}};
   localparam logic [ACC_W_DEF-1:0] SAT_NEG_DEF = {1'b1, {(ACC_W_DEF-1){1'b0}}};
endpackage

// File: rtl/psum_accumulator_adder.sv
// psum_adder: W-bit adder from rippled 4-bit CLA slices, raw sum plus signed overflow
module psum_adder #(
   parameter int W = 16
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] sum,
   output logic         ovf
);
   localparam int N = W / 4;
   logic [N-1:0] c;
   assign c[0] = 1'b0;
   for (genvar i = 0; i < N; i++) begin : g_slice
      logic [3:0] g, p, k;
      assign g = a[4*i +: 4] & b[4*i +: 4];
      assign p = a[4*i +: 4] ^ b[4*i +: 4];
      assign k[0] = c[i];
      assign k[1] = g[0] | (p[0] & k[0]);
      assign k[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & k[0]);
      assign k[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & k[0]);
      assign sum[4*i +: 4] = p ^ k;
      if (i < N - 1) begin : g_carry
         assign c[i+1] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                       | (p[3] & p[2] & p[1] & p[0] & k[0]);
      end
   end
   assign ovf = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);
endmodule

// File: rtl/psum_accumulator.sv
// psum_accumulator: saturating per-group partial-sum accumulator with valid/ready in and out
module psum_accumulator
   import psum_accumulator_pkg::*;
#(
   parameter int PROD_W = PROD_W_DEF,
   parameter int ACC_W  = ACC_W_DEF,
   parameter int CNT_W  = CNT_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [PROD_W-1:0] in_data,
   input  logic              in_last,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ACC_W-1:0]  out_sum,
   output logic              out_ovf,
   output logic [CNT_W-1:0]  out_cnt
);
   localparam logic [ACC_W-1:0] SAT_POS = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic [ACC_W-1:0] SAT_NEG = {1'b1, {(ACC_W-1){1'b0}}};
   state_t           state, nxt;
   logic [ACC_W-1:0] acc, ext, raw, acc_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic             ovf, ovf_n, add_ovf, take, start;
   assign in_ready  = (state != HOLD);
   assign out_valid = (state == HOLD);
   assign take      = in_valid && in_ready;
   assign start     = (state == IDLE);
   assign ext       = {{(ACC_W-PROD_W){in_data[PROD_W-1]}}, in_data};
   psum_adder #(.W(ACC_W)) u_add (
      .a   (acc),
      .b   (ext),
      .sum (raw),
      .ovf (add_ovf)
   );
   // post-update group values for the beat being accepted this cycle
   always_comb begin
      acc_n = start ? ext : (add_ovf ? (acc[ACC_W-1] ? SAT_NEG : SAT_POS) : raw);
      ovf_n = !start && (ovf || add_ovf);
      cnt_n = start ? CNT_W'(1) : ((&cnt) ? cnt : cnt + 1'b1);
   end
   // next state: accept moves toward HOLD on last, HOLD drains on out_ready
   always_comb begin
      nxt = state;
      if (take) nxt = in_last ? HOLD : ACCUM;
      else if (state == HOLD && out_ready) nxt = IDLE;
   end
   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else state <= nxt;
   end
   // running group state and result registers loaded on the last beat
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc     <= '0;
         ovf     <= 1'b0;
         cnt     <= '0;
         out_sum <= '0;
         out_ovf <= 1'b0;
         out_cnt <= '0;
      end else if (take) begin
         acc <= acc_n;
         ovf <= ovf_n;
         cnt <= cnt_n;
         if (in_last) begin
            out_sum <= acc_n;
            out_ovf <= ovf_n;
            out_cnt <= cnt_n;
         end
      end
   end
endmodule
